// File: rtl/mm_pkg.sv
// Shared definitions for the matrix feeder and matrix multiplier:
// data width, FSM state encodings and the transposed-index helper.
package mm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Row-major k = i*n + j maps to j*n + i (swap row and column fields).
    // Only meaningful for k < n*n, n = 2**lg.
    function automatic logic [IDX_W-1:0] transpose_idx(input logic [IDX_W-1:0] k,
                                                       input int unsigned   lg);
        logic [IDX_W-1:0] mask;
        mask = IDX_W'((32'd1 << lg) - 32'd1);
        return ((k & mask) << lg) | (k >> lg);
    endfunction

endpackage

// File: rtl/operand_buffer.sv
// n*n x DATA_W operand storage: one synchronous write port, one
// asynchronous read port. Deliberately unreset so contents survive reset.
// Ports:
//   clk        - clock
//   i_wr_en    - write strobe
//   i_wr_addr  - write address (row-major)
//   i_wr_data  - write word
//   i_rd_addr  - read address
//   o_rd_data  - read word (combinational)
module operand_buffer
    import mm_pkg::*;
#(
    parameter int unsigned log_size = 1
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [2*log_size-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0]       i_wr_data,
    input  logic [2*log_size-1:0]   i_rd_addr,
    output logic [DATA_W-1:0]       o_rd_data
);

    localparam int unsigned DEPTH = 2 ** (2 * log_size);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/matrix_feeder.sv
// Operand staging for matrix_multiplier: holds matrices A and B and, on
// start, streams n*n (A row-major, B column-major) word pairs over a
// strobe/acknowledge handshake.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   wr_en/wr_sel      - buffer write strobe and select (0 = A, 1 = B), IDLE only
//   wr_addr/wr_data   - row-major write address and word
//   start             - begin streaming (IDLE, wr_en low)
//   out_ack           - downstream accept
//   out_stb           - pair valid
//   a_out/b_out       - A word / B word of the current pair
//   busy              - high in STREAM and DONE
//   done              - one-cycle pulse after the last transfer
module matrix_feeder
    import mm_pkg::*;
#(
    parameter int unsigned log_size = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [2*log_size-1:0]   wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    input  logic                    out_ack,
    output logic                    out_stb,
    output logic [DATA_W-1:0]       a_out,
    output logic [DATA_W-1:0]       b_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned AW = 2 * log_size;
    localparam logic [AW-1:0] LAST_IDX = '1;   // n*n - 1

    state_t            r_state;
    logic [AW-1:0]     r_k;
    logic              r_out_stb;
    logic [DATA_W-1:0] r_a_out;
    logic [DATA_W-1:0] r_b_out;
    logic              r_busy;
    logic              r_done;

    logic [AW-1:0]     w_rd_idx;
    logic [AW-1:0]     w_b_idx;
    logic [DATA_W-1:0] w_a_rd;
    logic [DATA_W-1:0] w_b_rd;
    logic              w_wr_ok;
    logic              w_xfer;

    // Outputs are registered, so buffers are read one index ahead:
    // pair 0 when launching from IDLE, pair k+1 while streaming.
    assign w_rd_idx = (r_state == ST_STREAM) ? (r_k + AW'(1)) : '0;
    assign w_b_idx  = AW'(transpose_idx(IDX_W'(w_rd_idx), log_size));
    assign w_wr_ok  = wr_en && (r_state == ST_IDLE);
    assign w_xfer   = r_out_stb && out_ack;

    operand_buffer #(.log_size(log_size)) u_buf_a (
        .clk       (clk),
        .i_wr_en   (w_wr_ok && !wr_sel),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_idx),
        .o_rd_data (w_a_rd)
    );

    operand_buffer #(.log_size(log_size)) u_buf_b (
        .clk       (clk),
        .i_wr_en   (w_wr_ok && wr_sel),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_b_idx),
        .o_rd_data (w_b_rd)
    );

    // Streaming FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_out_stb <= 1'b0;
            r_a_out   <= '0;
            r_b_out   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !wr_en) begin
                        r_state   <= ST_STREAM;
                        r_k       <= '0;
                        r_out_stb <= 1'b1;
                        r_a_out   <= w_a_rd;
                        r_b_out   <= w_b_rd;
                        r_busy    <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (r_k == LAST_IDX) begin
                            r_state   <= ST_DONE;
                            r_out_stb <= 1'b0;
                            r_a_out   <= '0;
                            r_b_out   <= '0;
                            r_done    <= 1'b1;
                        end else begin
                            r_k     <= r_k + AW'(1);
                            r_a_out <= w_a_rd;
                            r_b_out <= w_b_rd;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_k     <= '0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_k       <= '0;
                    r_out_stb <= 1'b0;
                    r_a_out   <= '0;
                    r_b_out   <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign out_stb = r_out_stb;
    assign a_out   = r_a_out;
    assign b_out   = r_b_out;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
